// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing control for the decode-to-execute pipe. Tracks the
//   register writes in flight in EX, MEM and WB, and interlocks decode on RAW
//   hazards. It also applies EX-stage redirects, freezes the whole pipe while
//   data memory is busy, and drains the pipe after a HALT issues.
//
//   Optional build macro: FORWARDING_EN
//     defined   - EX/MEM->EX forwarding exists; only a load in EX (load-use) interlocks
//     undefined - full interlock against EX and MEM writers
//
// Ports
//   clk, rst                    clock (rising edge), async active-low reset
//   idValid                     decode holds a real instruction
//   idReadReg1/2, idReadUse1/2  decode source registers and their use flags
//   idWriteReg, idRegWrite      decode destination register and its write enable
//   idMemRead, idHalt           decode instruction is a load / is HALT
//   exRedirect                  EX resolved a taken branch/jump this cycle
//   memBusy                     data memory not ready
//   stall, nop, flush, freeze   pipe controls (hold IF/ID, bubble ID/EX, clear IF/ID, hold all)
//   halted                      pipe drained after HALT; sticky until reset
module pipeline_hazard_ctrl #(
  parameter int REG_BITS     = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idValid,
  input  logic [REG_BITS-1:0] idReadReg1,
  input  logic                idReadUse1,
  input  logic [REG_BITS-1:0] idReadReg2,
  input  logic                idReadUse2,
  input  logic [REG_BITS-1:0] idWriteReg,
  input  logic                idRegWrite,
  input  logic                idMemRead,
  input  logic                idHalt,
  input  logic                exRedirect,
  input  logic                memBusy,
  output logic                stall,
  output logic                nop,
  output logic                flush,
  output logic                freeze,
  output logic                halted
);

  localparam int CW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                isLoad;
  } sb_t;

  // Scoreboard: [0]=EX, [1]=MEM, [2]=WB
  sb_t [2:0]    r_sb;
  state_t       r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic w_m1, w_m2, w_hazard, w_issue;

`ifdef FORWARDING_EN
  // Forwarding covers ALU results; only a load still in EX is not ready yet.
  assign w_m1 = r_sb[0].valid & r_sb[0].isLoad & (r_sb[0].rd == idReadReg1);
  assign w_m2 = r_sb[0].valid & r_sb[0].isLoad & (r_sb[0].rd == idReadReg2);
`else
  assign w_m1 = (r_sb[0].valid & (r_sb[0].rd == idReadReg1)) |
                (r_sb[1].valid & (r_sb[1].rd == idReadReg1));
  assign w_m2 = (r_sb[0].valid & (r_sb[0].rd == idReadReg2)) |
                (r_sb[1].valid & (r_sb[1].rd == idReadReg2));
`endif

  // WB never hazards: the register file bypasses write to read.
  assign w_hazard = idValid & ((idReadUse1 & w_m1) | (idReadUse2 & w_m2));

  // The WB entry is kept for completeness of the in-flight view but never consulted.
  logic w_unused_wb;
  assign w_unused_wb = ^r_sb[2];

  always_comb begin
    stall       = 1'b0;
    nop         = 1'b0;
    flush       = 1'b0;
    freeze      = 1'b0;
    halted      = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!rst) begin
      // outputs held low throughout reset
    end else if (memBusy) begin
      freeze = 1'b1;
      halted = (r_state == S_HALTED);
    end else if (r_state == S_HALTED) begin
      stall  = 1'b1;
      nop    = 1'b1;
      halted = 1'b1;
    end else if (r_state == S_DRAIN) begin
      stall = 1'b1;
      nop   = 1'b1;
      if (r_cnt == '0) w_state_nxt = S_HALTED;
      else             w_cnt_nxt   = r_cnt - 1'b1;
    end else if (exRedirect) begin
      flush = 1'b1;
      nop   = 1'b1;
    end else if (w_hazard) begin
      stall = 1'b1;
      nop   = 1'b1;
    end else if (idValid && idHalt) begin
      w_state_nxt = S_DRAIN;
      w_cnt_nxt   = CW'(DRAIN_CYCLES - 1);
    end
  end

  assign w_issue = idValid & idRegWrite & ~nop & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_sb    <= '0;
    end else if (!freeze) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sb[2] <= r_sb[1];
      r_sb[1] <= r_sb[0];
      r_sb[0] <= w_issue ? '{valid: 1'b1, rd: idWriteReg, isLoad: idMemRead} : '0;
    end
  end

endmodule
